// File: rtl/slide_collector.sv
`default_nettype none
// ============================================================================
// Module   : slide_collector
// Purpose  : Buffers one frame of sliding-window results (raster order, tagged)
//            and replays it in raster order over a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module slide_collector #(
  parameter int DATA_W = 8,
  parameter int COLS   = 15,
  parameter int ROWS   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_row,
  input  logic [3:0]        in_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_row,
  output logic [3:0]        out_col,
  output logic              out_last,
  output logic              frame_done,
  output logic              err_order
);

  localparam int         c_DEPTH    = ROWS * COLS;
  localparam logic [3:0] c_LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] c_LAST_COL = 4'(COLS - 1);
  localparam logic [7:0] c_COLS8    = 8'(COLS);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_exp_row;
  logic [3:0]        r_exp_col;
  logic [3:0]        r_rd_row;
  logic [3:0]        r_rd_col;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [3:0]        r_out_row;
  logic [3:0]        r_out_col;
  logic              r_out_last;
  logic              r_frame_done;
  logic              r_err_order;
  logic [DATA_W-1:0] r_mem [c_DEPTH];

  logic       w_accept;
  logic       w_match;
  logic       w_wr_en;
  logic       w_exp_last;
  logic       w_rd_last;
  logic       w_hs;
  logic       w_load;
  logic [7:0] w_wr_addr;
  logic [7:0] w_rd_addr;

  assign w_accept   = (r_state == ST_FILL) && in_valid && r_in_ready;
  assign w_match    = (in_row == r_exp_row) && (in_col == r_exp_col);
  assign w_wr_en    = w_accept && w_match;
  assign w_exp_last = (r_exp_row == c_LAST_ROW) && (r_exp_col == c_LAST_COL);
  assign w_rd_last  = (r_rd_row == c_LAST_ROW) && (r_rd_col == c_LAST_COL);
  assign w_hs       = r_out_valid && out_ready;
  // Refill the output register when it is empty or being consumed, except on
  // the final handshake, which closes the frame instead.
  assign w_load     = (r_state == ST_DRAIN) && (!r_out_valid || out_ready) &&
                      !(w_hs && r_out_last);
  assign w_wr_addr  = {4'b0000, r_exp_row} * c_COLS8 + {4'b0000, r_exp_col};
  assign w_rd_addr  = {4'b0000, r_rd_row} * c_COLS8 + {4'b0000, r_rd_col};

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FILL;
      r_exp_row    <= 4'd0;
      r_exp_col    <= 4'd0;
      r_rd_row     <= 4'd0;
      r_rd_col     <= 4'd0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_row    <= 4'd0;
      r_out_col    <= 4'd0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_order  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_FILL: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (!w_match) begin
              r_err_order <= 1'b1;
            end else if (w_exp_last) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
              r_exp_row  <= 4'd0;
              r_exp_col  <= 4'd0;
              r_rd_row   <= 4'd0;
              r_rd_col   <= 4'd0;
            end else if (r_exp_col == c_LAST_COL) begin
              r_exp_col <= 4'd0;
              r_exp_row <= r_exp_row + 4'd1;
            end else begin
              r_exp_col <= r_exp_col + 4'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_hs && r_out_last) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= ST_FILL;
            r_in_ready   <= 1'b1;
            r_exp_row    <= 4'd0;
            r_exp_col    <= 4'd0;
          end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[w_rd_addr];
            r_out_row   <= r_rd_row;
            r_out_col   <= r_rd_col;
            r_out_last  <= w_rd_last;
            if (r_rd_col == c_LAST_COL) begin
              r_rd_col <= 4'd0;
              r_rd_row <= r_rd_row + 4'd1;
            end else begin
              r_rd_col <= r_rd_col + 4'd1;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign err_order  = r_err_order;

endmodule
`default_nettype wire

// File: tb/tb_slide_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_slide_collector
// Purpose  : Scoreboard bench for slide_collector (15x15 and 4x4 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_slide_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [7:0] in_data = 8'd0, out_data;
  logic [3:0] in_row = 4'd0, in_col = 4'd0, out_row, out_col;
  logic       out_last, frame_done, err_order;

  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [7:0] b_in_data = 8'd0, b_out_data;
  logic [3:0] b_in_row = 4'd0, b_in_col = 4'd0, b_out_row, b_out_col;
  logic       b_out_last, b_frame_done, b_err_order;

  slide_collector #(.DATA_W(8), .COLS(15), .ROWS(15)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_row(in_row), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .frame_done(frame_done), .err_order(err_order)
  );

  slide_collector #(.DATA_W(8), .COLS(4), .ROWS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_row(b_in_row), .in_col(b_in_col),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last),
    .frame_done(b_frame_done), .err_order(b_err_order)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] r;
    logic [3:0] c;
    logic       last;
  } ent_t;

  typedef struct {
    int seed;
    bit bp;
    bit ooo;
    bit hold_drain;
    bit exp_err;
  } scen_t;

  int   checks = 0, errors = 0;
  ent_t q[$];
  ent_t qb[$];
  int   hs_cnt = 0, fd_cnt = 0, hsb = 0, fdb = 0, lastb = 0;
  logic [3:0] m_row = 4'd0, m_col = 4'd0;
  bit   bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int   ph = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Backpressure pattern 1,0,0,1 while bp_mode is set
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_ready = bp_pat[ph];
      ph = (ph + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  bit   p_stall = 1'b0, p_last = 1'b0;
  ent_t p_out;
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      p_stall = 1'b0;
      p_last  = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {15'd0, out_data, out_row, out_col, out_last}, {15'd0, p_out});
      end
      if (p_last) begin
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ready_back", {31'd0, in_ready}, 32'd1);
      end else if (frame_done) begin
        chk("spurious_frame_done", {31'd0, frame_done}, 32'd0);
      end
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got=%0h required=none", {out_data, out_row, out_col, out_last});
        end else begin
          e = q.pop_front();
          chk("out_entry", {15'd0, out_data, out_row, out_col, out_last}, {15'd0, e});
        end
      end
      p_stall = out_valid && !out_ready;
      p_out   = {out_data, out_row, out_col, out_last};
      p_last  = out_valid && out_ready && out_last;
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      if (b_frame_done) fdb++;
      if (b_out_valid && b_out_ready) begin
        hsb++;
        if (b_out_last) lastb++;
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_output got=%0h required=none", b_out_data);
        end else begin
          e = qb.pop_front();
          chk("b_out_entry", {15'd0, b_out_data, b_out_row, b_out_col, b_out_last}, {15'd0, e});
        end
      end
    end
  end

  task automatic send_a(input logic [3:0] r, input logic [3:0] c, input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1; in_row = r; in_col = c; in_data = d;
    while (in_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (r == m_row && c == m_col) begin
      q.push_back({d, r, c, (r == 4'd14 && c == 4'd14)});
      if (m_col == 4'd14) begin
        m_col = 4'd0;
        m_row = (m_row == 4'd14) ? 4'd0 : m_row + 4'd1;
      end else begin
        m_col = m_col + 4'd1;
      end
    end
  endtask

  task automatic send_b(input logic [3:0] r, input logic [3:0] c, input logic [7:0] d);
    int t = 0;
    b_in_valid = 1'b1; b_in_row = r; b_in_col = c; b_in_data = d;
    while (b_in_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL b_send_timeout got in_ready=%b required=1", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    qb.push_back({d, r, c, (r == 4'd3 && c == 4'd3)});
  endtask

  task automatic reset_model();
    q.delete();
    m_row = 4'd0;
    m_col = 4'd0;
  endtask

  task automatic fill_frame(input scen_t s);
    for (int a = 0; a < 225; a++) begin
      if (s.ooo && a == 1) send_a(4'd0, 4'd2, 8'hEE);
      send_a(4'(a / 15), 4'(a % 15), 8'(a + s.seed));
    end
    chk("ready_drop", {31'd0, in_ready}, 32'd0);
    chk("no_early_valid", {31'd0, out_valid}, 32'd0);
    if (s.hold_drain) begin
      in_valid = 1'b1; in_row = 4'd0; in_col = 4'd0; in_data = 8'h5A;
    end
    @(posedge clk); #1;
    chk("first_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_frame(input scen_t s);
    int hs0, t;
    hs0 = hs_cnt;
    bp_mode = s.bp;
    fill_frame(s);
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) break;
    end
    if (t >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout got handshakes=%0d required=225", hs_cnt - hs0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    bp_mode = 1'b0;
    chk("handshakes", hs_cnt - hs0, 32'd225);
    chk("err_order", {31'd0, err_order}, {31'd0, s.exp_err});
    chk("scoreboard_empty", q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outs", {12'd0, out_valid, out_data, out_row, out_col, out_last, frame_done, err_order}, 32'd0);
  endtask

  scen_t tbl[4];

  initial begin
    int t, hs0;
    tbl[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{11, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{7,  1'b0, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 4; i++) run_frame(tbl[i]);

    // Reset part-way through filling, then a clean frame
    for (int a = 0; a < 100; a++) send_a(4'(a / 15), 4'(a % 15), 8'(a + 50));
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs();
    reset_model();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_fill_rst", {31'd0, in_ready}, 32'd1);
    run_frame('{20, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset part-way through draining, then a clean frame
    fill_frame('{40, 1'b0, 1'b0, 1'b0, 1'b0});
    hs0 = hs_cnt;
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (hs_cnt - hs0 >= 50) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs();
    reset_model();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_drain_rst", {31'd0, in_ready}, 32'd1);
    run_frame('{90, 1'b1, 1'b0, 1'b0, 1'b0});

    // Back-to-back frames on the 4x4 instance
    for (int f = 0; f < 2; f++)
      for (int a = 0; a < 16; a++)
        send_b(4'(a / 4), 4'(a % 4), (f == 0) ? 8'(a * 3 + 1) : (8'(a) ^ 8'hA5));
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (fdb >= 2) break;
    end
    chk("b_handshakes", hsb, 32'd32);
    chk("b_frame_done", fdb, 32'd2);
    chk("b_last_count", lastb, 32'd2);
    chk("b_err_order", {31'd0, b_err_order}, 32'd0);
    chk("b_scoreboard_empty", qb.size(), 32'd0);
    chk("b_ready_back", {31'd0, b_in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/slide_collector.md
Name: slide_collector

Overview:
- Capture side of the 15x15 sliding-window sweep. Accepts one result per window position, in raster order with (row, col) tags, into a ROWS*COLS result buffer.
- Once the buffer holds a full frame, it replays the results in raster order to a downstream consumer over a valid/ready interface.
- Sits between the window compute datapath, which is sequenced by the slide counter, and the next DNN layer or host readout.

Parameters:
- DATA_W, 8, width of one window result
- COLS, 15, window positions per row (1..16)
- ROWS, 15, window rows per frame (1..16)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  result present on in_data this cycle
- in_ready  output  1  block accepts input (high only in FILL)
- in_data  input  DATA_W  window result
- in_row  input  4  row tag of result
- in_col  input  4  column tag of result
- out_valid  output  1  out_data/out_row/out_col/out_last valid
- out_ready  input  1  downstream accepts output
- out_data  output  DATA_W  buffered result
- out_row  output  4  row tag of out_data
- out_col  output  4  column tag of out_data
- out_last  output  1  high with the final (ROWS-1, COLS-1) entry
- frame_done  output  1  one-cycle pulse after the last output handshake
- err_order  output  1  sticky: an out-of-order input was dropped

Behaviour:
- Reset values: in_ready=0 during reset and 1 the cycle after. All other outputs are 0. State=FILL. Expected row/col counters=0. Buffer contents don't care.
- Storage: ROWS*COLS entries of DATA_W. Address = row*COLS + col, 8 bits.
- FILL state:
  - in_ready=1.
  - An accept occurs when in_valid=1 and in_ready=1.
  - If (in_row, in_col) equals the expected (exp_row, exp_col), in_data is written and the expected position advances in raster order: col wraps at COLS-1 to 0 and row increments.
  - If the tag mismatches, the sample is dropped, err_order is set, and the counters hold.
  - Accepting (ROWS-1, COLS-1) moves the state to DRAIN on the next edge, and in_ready drops that same edge.
- DRAIN state:
  - in_ready=0. in_valid is ignored, with no write and no error.
  - A read pointer starts at (0,0). The output stage is registered: out_valid first rises 1 cycle after DRAIN entry, giving 1-cycle latency from the final input accept to the first out_valid.
  - A handshake occurs when out_valid=1 and out_ready=1. On a handshake the next entry is presented on the following cycle, so full throughput is 1 per cycle with out_ready held high.
  - out_valid=1 with out_ready=0: out_data/out_row/out_col/out_last hold stable and out_valid stays high.
  - out_last=1 only with entry (ROWS-1, COLS-1).
  - The handshake on the out_last entry:
    - drops out_valid next cycle
    - pulses frame_done for 1 cycle
    - returns the state to FILL with expected counters=0
    - raises in_ready next cycle.
- err_order clears only on rst. It persists across frames.
- Simultaneous events:
  - A final input accept and in_valid on the next cycle: the second sample is not accepted (in_ready=0).
  - The last output handshake and in_valid in the same cycle: no accept, because in_ready is still 0.
- Reset mid-FILL or mid-DRAIN: the partial frame is discarded, all outputs return to reset values on the next edge, and the next frame starts at (0,0).
- Tags are 4 bits. Inputs with in_col>=COLS or in_row>=ROWS never match and are dropped with err_order set.

Test Plan:
- Full frame, out_ready=1:
  - Stimulus: 225 in-order samples, in_data=address.
  - Required: first out_valid 1 cycle after last accept. Outputs 0..224 on consecutive cycles with row/col tags matching. out_last on (14,14). frame_done one cycle after. in_ready back high.
- Backpressure:
  - Stimulus: during DRAIN, toggle out_ready 1,0,0,1 repeatedly.
  - Required: no duplicated or skipped entries. Outputs stay stable while stalled. Exactly 225 handshakes.
- Out-of-order:
  - Stimulus: after (0,0), send (0,2), then (0,1)..(14,14).
  - Required: (0,2) dropped and err_order=1. Frame completes after 225 good samples. Drained data excludes the dropped value.
- Input during DRAIN:
  - Stimulus: hold in_valid=1 with tag (0,0) throughout DRAIN.
  - Required: in_ready=0, buffer unchanged, err_order unchanged.
- Reset mid-operation:
  - Stimulus: rst after 100 accepts, then a full new frame. Separately, rst after 50 output handshakes.
  - Required: outputs return to reset values. The new frame drains correctly from (0,0).
- Back-to-back frames:
  - Stimulus: two frames with different data, with ROWS=COLS=4 as a parameter override.
  - Required: 16 outputs per frame, out_last on (3,3), two frame_done pulses, and err_order=0.
